// File: rtl/char_scan_ctrl.sv
// Dot-matrix refresh sequencer: scans a character buffer through a registered
// font ROM and streams each glyph column by column with a fixed dwell time.
module char_scan_ctrl #(
   parameter int         NUM_CHARS = 8,
   parameter int         DWELL     = 4,
   parameter logic [5:0] BLANK     = 6'h3F,
   localparam int        AW        = $clog2(NUM_CHARS),
   localparam int        SW        = $clog2(NUM_CHARS * 7)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [5:0]    wr_code,
   output logic [5:0]    font_code,
   input  logic [7:0]    font_col0,
   input  logic [7:0]    font_col1,
   input  logic [7:0]    font_col2,
   input  logic [7:0]    font_col3,
   input  logic [7:0]    font_col4,
   input  logic [7:0]    font_col5,
   input  logic [7:0]    font_col6,
   output logic [7:0]    col_data,
   output logic [SW-1:0] col_sel,
   output logic          col_valid,
   output logic          frame_done
);

   // state | meaning
   // IDLE  | not scanning, waits for en
   // FETCH | font_code stable, ROM samples it
   // WAIT  | ROM output valid, captured into shadow at end of cycle
   // SHOW  | columns of the captured glyph driven, DWELL cycles each

   localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [AW-1:0]   LAST_CHAR  = AW'(NUM_CHARS - 1);
   localparam logic [DW-1:0]   LAST_DWELL = DW'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHOW} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] char_idx, char_nxt;
   logic [2:0]    col_idx, col_nxt;
   logic [DW-1:0] dwell_cnt, dwell_nxt;
   logic          load_font;
   logic [5:0]    char_buf [NUM_CHARS];
   logic [7:0]    shadow [7];
   logic [7:0]    shadow_col;
   logic [7:0]    col_data_nxt;
   logic [SW-1:0] col_sel_nxt;
   logic          frame_done_nxt;
   logic          wr_ok;

   assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW + 1)'(NUM_CHARS));

   always_comb begin
      state_nxt = state;
      char_nxt  = char_idx;
      col_nxt   = col_idx;
      dwell_nxt = dwell_cnt;
      load_font = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = FETCH;
               char_nxt  = '0;
               load_font = 1'b1;
            end
         end
         FETCH: state_nxt = WAIT;
         WAIT: begin
            state_nxt = SHOW;
            col_nxt   = 3'd0;
            dwell_nxt = '0;
         end
         SHOW: begin
            if (dwell_cnt == LAST_DWELL) begin
               dwell_nxt = '0;
               if (col_idx != 3'd6) begin
                  col_nxt = col_idx + 3'd1;
               end else begin
                  char_nxt = (char_idx == LAST_CHAR) ? '0 : char_idx + AW'(1);
                  if (en) begin
                     state_nxt = FETCH;
                     load_font = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end else begin
               dwell_nxt = dwell_cnt + DW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shadow_col = shadow[0];
      case (col_nxt)
         3'd1:    shadow_col = shadow[1];
         3'd2:    shadow_col = shadow[2];
         3'd3:    shadow_col = shadow[3];
         3'd4:    shadow_col = shadow[4];
         3'd5:    shadow_col = shadow[5];
         3'd6:    shadow_col = shadow[6];
         default: shadow_col = shadow[0];
      endcase
   end

   // Outputs are registered from next-state values so they line up with the
   // state they describe (e.g. frame_done lands in the last cycle of the frame).
   always_comb begin
      col_data_nxt = 8'h00;
      if (state == WAIT) begin
         col_data_nxt = font_col0;
      end else if (state_nxt == SHOW) begin
         col_data_nxt = shadow_col;
      end
      col_sel_nxt    = SW'(char_nxt) * SW'(7) + SW'(col_nxt);
      frame_done_nxt = (state_nxt == SHOW) && (char_nxt == LAST_CHAR) &&
                       (col_nxt == 3'd6) && (dwell_nxt == LAST_DWELL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         char_idx   <= '0;
         col_idx    <= 3'd0;
         dwell_cnt  <= '0;
         font_code  <= BLANK;
         col_data   <= 8'h00;
         col_sel    <= '0;
         col_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         char_idx   <= char_nxt;
         col_idx    <= col_nxt;
         dwell_cnt  <= dwell_nxt;
         col_data   <= col_data_nxt;
         col_sel    <= col_sel_nxt;
         col_valid  <= (state_nxt == SHOW);
         frame_done <= frame_done_nxt;
         // Buffer read sees the pre-write contents on a same-edge write.
         if (load_font) begin
            font_code <= char_buf[char_nxt];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CHARS; i++) begin
            char_buf[i] <= BLANK;
         end
      end else if (wr_ok) begin
         char_buf[wr_addr] <= wr_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 7; i++) begin
            shadow[i] <= 8'h00;
         end
      end else if (state == WAIT) begin
         shadow[0] <= font_col0;
         shadow[1] <= font_col1;
         shadow[2] <= font_col2;
         shadow[3] <= font_col3;
         shadow[4] <= font_col4;
         shadow[5] <= font_col5;
         shadow[6] <= font_col6;
      end
   end

endmodule

// File: tb/tb_char_scan_ctrl.sv
// Bench for char_scan_ctrl: models the 1-cycle font ROM and checks the column
// stream against a scoreboard queue filled as each scan is started.
module tb_char_scan_ctrl;

   localparam logic [0:6][7:0] G_BLANK = '0;
   localparam logic [0:6][7:0] G_ONE   = {8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00};
   localparam logic [0:6][7:0] G_PLUS  = {8'h00, 8'h08, 8'h08, 8'h3E, 8'h08, 8'h08, 8'h00};
   localparam logic [0:6][7:0] G_NINE  = {8'h00, 8'h26, 8'h49, 8'h49, 8'h49, 8'h3E, 8'h00};

   typedef struct packed {
      logic            do_wr;
      logic [5:0]      code0;
      logic [5:0]      code1;
      logic [0:6][7:0] g0;
      logic [0:6][7:0] g1;
   } row_t;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] data;
      logic       fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, wr_en = 1'b0;
   logic [0:0] wr_addr = '0;
   logic [5:0] wr_code = '0;
   logic [5:0] font_code;
   logic [7:0] font_col [7];
   logic [7:0] col_data;
   logic [3:0] col_sel;
   logic       col_valid, frame_done;

   logic       en2 = 1'b0, wr_en2 = 1'b0;
   logic [1:0] wr_addr2 = '0;
   logic [5:0] wr_code2 = '0;
   logic [5:0] font_code2;
   logic [7:0] col_data2;
   logic [4:0] col_sel2;
   logic       col_valid2, frame_done2;

   int   n_checks = 0;
   int   n_fail = 0;
   int   negcnt = 0;
   int   last_valid = -1;
   int   last_fd = -1;
   bit   fd_chk = 0;
   logic prev_valid = 1'b0;
   exp_t exp_q[$];
   row_t rows[3];

   always #5 clk = ~clk;

   char_scan_ctrl #(.NUM_CHARS(2), .DWELL(2), .BLANK(6'h3F)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_code(wr_code), .font_code(font_code),
      .font_col0(font_col[0]), .font_col1(font_col[1]), .font_col2(font_col[2]),
      .font_col3(font_col[3]), .font_col4(font_col[4]), .font_col5(font_col[5]),
      .font_col6(font_col[6]), .col_data(col_data), .col_sel(col_sel),
      .col_valid(col_valid), .frame_done(frame_done)
   );

   char_scan_ctrl #(.NUM_CHARS(3), .DWELL(1), .BLANK(6'h3F)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .wr_en(wr_en2), .wr_addr(wr_addr2),
      .wr_code(wr_code2), .font_code(font_code2),
      .font_col0(8'h00), .font_col1(8'h00), .font_col2(8'h00), .font_col3(8'h00),
      .font_col4(8'h00), .font_col5(8'h00), .font_col6(8'h00),
      .col_data(col_data2), .col_sel(col_sel2),
      .col_valid(col_valid2), .frame_done(frame_done2)
   );

   function automatic logic [0:6][7:0] glyph(input logic [5:0] c);
      case (c)
         6'h01:   return G_ONE;
         6'h3E:   return G_PLUS;
         6'h09:   return G_NINE;
         default: return G_BLANK;
      endcase
   endfunction

   // Registered font ROM: one cycle from font_code to columns.
   always @(posedge clk) begin
      logic [0:6][7:0] g;
      g = glyph(font_code);
      for (int i = 0; i < 7; i++) font_col[i] <= g[i];
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      negcnt++;
      if (!rst_n) begin
         last_valid = -1;
         last_fd    = -1;
         prev_valid = 1'b0;
      end else begin
         if (col_valid) begin
            if (!prev_valid && last_valid >= 0 && (negcnt - last_valid - 1) < 8)
               check("char_gap", negcnt - last_valid - 1, 2);
            check("unexpected_col", int'(exp_q.size() == 0), 0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("col_sel", col_sel, e.sel);
               check("col_data", col_data, e.data);
               check("frame_done", frame_done, e.fd);
            end
            last_valid = negcnt;
         end else begin
            check("frame_done_idle", frame_done, 0);
         end
         if (frame_done) begin
            if (fd_chk && last_fd >= 0) check("frame_period", negcnt - last_fd, 32);
            last_fd = negcnt;
         end
         prev_valid = col_valid;
      end
   end

   task automatic push_char(input int idx, input logic [0:6][7:0] g);
      exp_t e;
      for (int c = 0; c < 7; c++)
         for (int d = 0; d < 2; d++) begin
            e.sel  = 4'(idx * 7 + c);
            e.data = g[c];
            e.fd   = (idx == 1 && c == 6 && d == 1);
            exp_q.push_back(e);
         end
   endtask

   task automatic push_frame(input logic [0:6][7:0] g0, input logic [0:6][7:0] g1);
      push_char(0, g0);
      push_char(1, g1);
   endtask

   task automatic wait_q_le(input int n, input string name);
      int k;
      k = 0;
      while (exp_q.size() > n && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(name, int'(exp_q.size() > n), 0);
      if (exp_q.size() > n) exp_q.delete();
   endtask

   task automatic check_latency(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!col_valid && k < 20);
      check(name, k, 3);
   endtask

   task automatic write_buf(input logic [0:0] a, input logic [5:0] c);
      wr_en = 1'b1; wr_addr = a; wr_code = c;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [5:0] codes2 [3];
      int         nc;
      logic       pv;

      rows[0] = '{do_wr: 1'b0, code0: 6'h3F, code1: 6'h3F, g0: G_BLANK, g1: G_BLANK};
      rows[1] = '{do_wr: 1'b1, code0: 6'h01, code1: 6'h3E, g0: G_ONE,   g1: G_PLUS};
      rows[2] = '{do_wr: 1'b1, code0: 6'h09, code1: 6'h01, g0: G_NINE,  g1: G_ONE};

      #12;
      check("rst_font_code", font_code, 6'h3F);
      check("rst_col_data", col_data, 0);
      check("rst_col_sel", col_sel, 0);
      check("rst_col_valid", col_valid, 0);
      check("rst_frame_done", frame_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      foreach (rows[r]) begin
         if (rows[r].do_wr) begin
            write_buf(1'b0, rows[r].code0);
            write_buf(1'b1, rows[r].code1);
         end
         push_frame(rows[r].g0, rows[r].g1);
         en = 1'b1;
         check_latency("first_valid_lat");
         wait_q_le(7, "row_timeout");
         en = 1'b0;
         wait_q_le(0, "row_timeout");
         idle(10);
         check("row_idle_valid", col_valid, 0);
      end

      // Two back-to-back frames: frame_done period and wrap gap.
      write_buf(1'b0, 6'h01);
      write_buf(1'b1, 6'h3E);
      push_frame(G_ONE, G_PLUS);
      push_frame(G_ONE, G_PLUS);
      fd_chk = 1;
      last_fd = -1;
      en = 1'b1;
      wait_q_le(7, "cont_timeout");
      en = 1'b0;
      wait_q_le(0, "cont_timeout");
      fd_chk = 0;
      idle(10);

      // Drop en in the middle of char0: char completes, then idle.
      push_char(0, G_ONE);
      en = 1'b1;
      wait_q_le(8, "drop_timeout");
      en = 1'b0;
      wait_q_le(0, "drop_timeout");
      idle(20);
      check("drop_idle_valid", col_valid, 0);
      push_frame(G_ONE, G_PLUS);
      en = 1'b1;
      check_latency("restart_lat");
      check("restart_sel", col_sel, 0);
      wait_q_le(7, "restart_timeout");
      en = 1'b0;
      wait_q_le(0, "restart_timeout");
      idle(10);

      // Write to entry 0 on the same edge that fetches it.
      push_frame(G_ONE, G_PLUS);
      push_frame(G_NINE, G_PLUS);
      en = 1'b1; wr_en = 1'b1; wr_addr = 1'b0; wr_code = 6'h09;
      @(negedge clk);
      wr_en = 1'b0;
      wait_q_le(7, "wrfetch_timeout");
      en = 1'b0;
      wait_q_le(0, "wrfetch_timeout");
      idle(10);

      // Asynchronous reset during char1.
      push_frame(G_NINE, G_PLUS);
      en = 1'b1;
      wait_q_le(10, "rst_scan_timeout");
      check("pre_rst_valid", col_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_col_valid", col_valid, 0);
      check("async_col_data", col_data, 0);
      check("async_col_sel", col_sel, 0);
      check("async_font_code", font_code, 6'h3F);
      exp_q.delete();
      idle(3);
      push_frame(G_BLANK, G_BLANK);
      rst_n = 1'b1;
      check_latency("post_rst_lat");
      check("post_rst_font_code", font_code, 6'h3F);
      wait_q_le(7, "post_rst_timeout");
      en = 1'b0;
      wait_q_le(0, "post_rst_timeout");
      idle(10);

      // Out-of-range write on a 3-char instance (DWELL=1): entry 2 only.
      @(negedge clk);
      wr_en2 = 1'b1; wr_addr2 = 2'd2; wr_code2 = 6'h05;
      @(negedge clk);
      wr_addr2 = 2'd3; wr_code2 = 6'h01;
      @(negedge clk);
      wr_en2 = 1'b0;
      en2 = 1'b1;
      nc = 0;
      pv = 1'b0;
      for (int k = 0; k < 40 && nc < 3; k++) begin
         @(negedge clk);
         if (col_valid2 && !pv) begin
            codes2[nc] = font_code2;
            nc++;
         end
         pv = col_valid2;
      end
      en2 = 1'b0;
      check("oor_char_count", nc, 3);
      if (nc == 3) begin
         check("oor_code0", codes2[0], 6'h3F);
         check("oor_code1", codes2[1], 6'h3F);
         check("oor_code2", codes2[2], 6'h05);
      end
      idle(15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
